// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response bundle between the control path, alu_op_sequencer and the alu datapath.
interface alu_op_sequencer_if #(parameter int WIDTH = 32);
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_op;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic [3:0]         alu_sel;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   alu_b;
  logic [2*WIDTH-1:0] alu_c;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_lo;
  logic [WIDTH-1:0]   rsp_hi;
  logic               rsp_err;
  logic               busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_c, rsp_ready,
    output req_ready, alu_sel, alu_a, alu_y, alu_b,
           rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_c, rsp_ready,
    input  req_ready, alu_sel, alu_a, alu_y, alu_b,
           rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// One-at-a-time ALU operation sequencer: stages operands, holds alu_sel, captures {HI,LO}.
// Optional ALU_SEQ_DIVZERO_EN: reject DIV with B==0 at accept instead of issuing it.
//
// state | meaning
// IDLE  | ready for a request; outputs hold last values
// LOADY | operands staged on alu_a/alu_y/alu_b, alu_sel held at 0000
// EXEC  | alu_sel driven with the latched op (MD_CYCLES cycles for MUL/DIV)
// CAPT  | alu_sel back to 0000; ALU result captured on exit
// RESP  | response valid until taken
module alu_op_sequencer #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOADY, EXEC, CAPT, RESP} state_t;

  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  state_t     state;
  logic [3:0] op_q;
  logic [3:0] cnt;
  logic       reject;
  logic       op_md;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b1001, 4'b1011: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

  always_comb begin
    reject = !op_legal(bus.req_op);
`ifdef ALU_SEQ_DIVZERO_EN
    if (bus.req_op == OP_DIV && bus.req_b == '0) reject = 1'b1;
`endif
  end

  assign op_md         = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= 4'd0;
      cnt           <= 4'd0;
      bus.alu_sel   <= 4'd0;
      bus.alu_a     <= '0;
      bus.alu_y     <= '0;
      bus.alu_b     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_lo    <= '0;
      bus.rsp_hi    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            if (reject) begin
              // Rejected requests never touch the ALU operand lines.
              bus.rsp_lo    <= '0;
              bus.rsp_hi    <= '0;
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.alu_a <= bus.req_a;
              bus.alu_y <= bus.req_a;
              bus.alu_b <= bus.req_b;
              state     <= LOADY;
            end
          end
        end
        LOADY: begin
          bus.alu_sel <= op_q;
          cnt         <= op_md ? MD_LOAD : 4'd0;
          state       <= EXEC;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            bus.alu_sel <= 4'd0;
            state       <= CAPT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CAPT: begin
          bus.rsp_lo    <= bus.alu_c[WIDTH-1:0];
          bus.rsp_hi    <= op_md ? bus.alu_c[2*WIDTH-1:WIDTH] : '0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a registered behavioural ALU and a transaction-level reference.
module tb_alu_op_sequencer;
  localparam int W  = 32;
  localparam int MD = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W), .MD_CYCLES(MD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ALU behaviour; upper half of non-MUL/DIV results is deliberately junk.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] y, input logic [31:0] b);
    logic [4:0]  s;
    logic [63:0] yy;
    logic [63:0] t;
    s  = b[4:0];
    yy = {y, y};
    case (op)
      4'b0001: return {~y, y + b};
      4'b0010: return {~y, y - b};
      4'b0011: return 64'(y) * 64'(b);
      4'b0101: return (b == 0) ? {y, 32'hFFFF_FFFF} : {y % b, y / b};
      4'b0110: return {~y, y & b};
      4'b0111: return {~y, y | b};
      4'b1000: return {~y, 32'd0 - y};
      4'b1010: return {~y, ~y};
      4'b1100: return {~y, y << s};
      4'b1101: return {~y, y >> s};
      4'b1110: begin t = yy << s; return {~y, t[63:32]}; end
      4'b1111: begin t = yy >> s; return {~y, t[31:0]}; end
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk)
    if (bus.alu_sel != 4'd0) bus.alu_c <= alu_fn(bus.alu_sel, bus.alu_y, bus.alu_b);

  function automatic bit is_rejected(input logic [3:0] op, input logic [31:0] b);
    bit r;
    r = (op == 4'b0000) || (op == 4'b0100) || (op == 4'b1001) || (op == 4'b1011);
`ifdef ALU_SEQ_DIVZERO_EN
    if (op == 4'b0101 && b == 0) r = 1'b1;
`endif
    return r;
  endfunction

  // Runs one transaction from IDLE; sampling is #1 after each rising edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    bit          rej;
    bit          md;
    logic [63:0] res;
    logic [31:0] exp_lo, exp_hi;
    int          exp_lat, exp_sel, lat, sel_n, bad_sel, bad_opnd;
    rej     = is_rejected(op, b);
    md      = (op == 4'b0011) || (op == 4'b0101);
    res     = alu_fn(op, a, b);
    exp_lo  = rej ? 32'd0 : res[31:0];
    exp_hi  = (rej || !md) ? 32'd0 : res[63:32];
    exp_lat = rej ? 0 : (md ? 2 + MD : 3);
    exp_sel = rej ? 0 : (md ? MD : 1);

    chk("idle_ready", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = (stall == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; sel_n = 0; bad_sel = 0; bad_opnd = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.alu_sel == op) begin
        sel_n++;
        if (bus.alu_a != a || bus.alu_y != a || bus.alu_b != b) bad_opnd++;
      end else if (bus.alu_sel != 4'd0) bad_sel++;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency op=%0h", op), 64'(lat), 64'(exp_lat));
    chk($sformatf("sel_cycles op=%0h", op), 64'(sel_n), 64'(exp_sel));
    chk("stray_sel", 64'(bad_sel), 64'd0);
    chk("operands", 64'(bad_opnd), 64'd0);
    chk($sformatf("rsp_err op=%0h", op), {63'd0, bus.rsp_err}, {63'd0, rej});
    chk($sformatf("rsp_lo op=%0h a=%0h b=%0h", op, a, b), 64'(bus.rsp_lo), 64'(exp_lo));
    chk($sformatf("rsp_hi op=%0h a=%0h b=%0h", op, a, b), 64'(bus.rsp_hi), 64'(exp_hi));

    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 4'b0001;
      @(posedge clk); #1;
      chk("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("stall_lo", 64'(bus.rsp_lo), 64'(exp_lo));
      chk("stall_hi", 64'(bus.rsp_hi), 64'(exp_hi));
      chk("stall_ready", {63'd0, bus.req_ready}, 64'd0);
      chk("stall_busy", {63'd0, bus.busy}, 64'd1);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("post_hs_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("post_hs_idle", {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    chk({tag, "_err"}, {63'd0, bus.rsp_err}, 64'd0);
    chk({tag, "_rsp"}, {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    chk({tag, "_sel"}, 64'(bus.alu_sel), 64'd0);
    chk({tag, "_ops"}, 64'(bus.alu_a | bus.alu_y | bus.alu_b), 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #23;
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'b0001, 32'd5, 32'd7, 0);
    run_op(4'b0011, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(4'b0101, 32'd17, 32'd5, 0);
    run_op(4'b0101, 32'd17, 32'd0, 0);
    run_op(4'b0100, 32'd9, 32'd9, 0);
    run_op(4'b0010, 32'd10, 32'd3, 5);
    run_op(4'b1110, 32'h8000_0001, 32'd1, 1);

    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(op, a, b, $urandom_range(0, 3));
    end

    // Reset in the middle of a MUL execution.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b0011;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_exec_sel", 64'(bus.alu_sel), 64'h3);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_valid", {63'd0, bus.rsp_valid}, 64'd0);
    end
    rst_n = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    run_op(4'b0001, 32'd1, 32'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
